// File: rtl/count_sequence_checker_if.sv
// Reader-side bus of the 4-bit up/down loadable counter.
// Harness drives samples; the checker returns lock/error/wrap status.
interface count_sequence_checker_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_WIDTH = 8
);
  logic                 sample;
  logic [WIDTH-1:0]     value;
  logic                 count;
  logic                 load;
  logic [WIDTH-1:0]     load_val;
  logic                 clear_err;
  logic                 locked;
  logic                 error;
  logic                 wrap;
  logic [ERR_WIDTH-1:0] err_count;

  modport master (
    output sample,
    output value,
    output count,
    output load,
    output load_val,
    output clear_err,
    input  locked,
    input  error,
    input  wrap,
    input  err_count
  );

  modport slave (
    input  sample,
    input  value,
    input  count,
    input  load,
    input  load_val,
    input  clear_err,
    output locked,
    output error,
    output wrap,
    output err_count
  );
endinterface

// File: rtl/count_sequence_checker.sv
// Step-by-step monitor of an up/down loadable counter.
// Acquires lock, flags mismatches, counts errors, reports wraps.
module count_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_WIDTH  = 8
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  count_sequence_checker_if.slave mon_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;
  localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [3:0]           good_q, good_d;
  logic                 locked_q, locked_d;
  logic                 error_q, error_d;
  logic                 wrap_q, wrap_d;
  logic [ERR_WIDTH-1:0] errcnt_q, errcnt_d;

  logic [WIDTH-1:0] exp_val;
  logic             match;
  logic             wrap_step;
  logic             err_inc;
  logic [3:0]       good_inc;

  always_comb begin
    exp_val = prev_q - ZERO;
    priority case (1'b1)
      mon_if.load:  exp_val = mon_if.load_val;
      !mon_if.count: exp_val = prev_q + WIDTH'(1);
      default:      exp_val = prev_q - WIDTH'(1);
    endcase
  end

  assign match    = (mon_if.value == exp_val);
  assign good_inc = good_q + 4'd1;

  // A load landing on 0 is never a wrap, even from max.
  always_comb begin
    wrap_step = 1'b0;
    if (match && !mon_if.load) begin
      if (!mon_if.count)
        wrap_step = (prev_q == MAX) && (mon_if.value == ZERO);
      else
        wrap_step = (prev_q == ZERO) && (mon_if.value == MAX);
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    error_d = 1'b0;
    wrap_d  = 1'b0;
    err_inc = 1'b0;
    if (mon_if.sample) begin
      prev_d = mon_if.value;
      unique case (state_q)
        S_IDLE: begin
          good_d  = 4'd0;
          state_d = S_ACQUIRE;
        end
        S_ACQUIRE: begin
          if (match) begin
            good_d = good_inc;
            wrap_d = wrap_step;
            if (good_inc == LOCK_N)
              state_d = S_LOCKED;
          end else begin
            good_d = 4'd0;
          end
        end
        S_LOCKED: begin
          if (match) begin
            wrap_d = wrap_step;
          end else begin
            error_d = 1'b1;
            err_inc = 1'b1;
            good_d  = 4'd0;
            state_d = S_ACQUIRE;
          end
        end
        default: begin
          good_d  = 4'd0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign locked_d = (state_d == S_LOCKED);

  // A clear racing an error keeps that error visible as a count of one.
  always_comb begin
    errcnt_d = errcnt_q;
    if (mon_if.clear_err)
      errcnt_d = err_inc ? ERR_ONE : '0;
    else if (err_inc && errcnt_q != ERR_MAX)
      errcnt_d = errcnt_q + ERR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      wrap_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      wrap_q   <= wrap_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign mon_if.locked    = locked_q;
  assign mon_if.error     = error_q;
  assign mon_if.wrap      = wrap_q;
  assign mon_if.err_count = errcnt_q;

  a_err_wrap_excl: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(error_q && wrap_q));

  a_lock_state: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    locked_q == (state_q == S_LOCKED));

  a_err_only_locked: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    error_d |-> (state_q == S_LOCKED));

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker.
// Hand-computed expectations, LOCK_COUNT = 3, WIDTH = 4.
module tb_count_sequence_checker;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [3:0] p;

  count_sequence_checker_if #(.WIDTH(4), .ERR_WIDTH(8)) cif ();

  count_sequence_checker #(
    .WIDTH(4),
    .LOCK_COUNT(3),
    .ERR_WIDTH(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .mon_if(cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic c,
                      input logic ld, input logic [3:0] lv);
    cif.sample   = 1'b1;
    cif.value    = v;
    cif.count    = c;
    cif.load     = ld;
    cif.load_val = lv;
    @(posedge clk);
    #1;
    cif.sample = 1'b0;
    cif.load   = 1'b0;
    p = v;
  endtask

  task automatic up(input logic [3:0] v);
    step(v, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic dn(input logic [3:0] v);
    step(v, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic relock();
    repeat (3) up(4'(p + 4'd1));
  endtask

  task automatic force_err();
    relock();
    up(4'(p + 4'd3));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    p = 4'd0;
    rst_n = 1'b0;
    cif.sample = 1'b0;
    cif.value = 4'd0;
    cif.count = 1'b0;
    cif.load = 1'b0;
    cif.load_val = 4'd0;
    cif.clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", cif.locked, 0);
    chk("rst_error", cif.error, 0);
    chk("rst_wrap", cif.wrap, 0);
    chk("rst_errcnt", cif.err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    up(4'd5);
    up(4'd6);
    up(4'd7);
    chk("acq_locked_7", cif.locked, 0);
    up(4'd8);
    chk("lock_after_8", cif.locked, 1);
    chk("lock_no_err", cif.error, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_hold_lock", cif.locked, 1);

    for (int v = 9; v <= 15; v++) up(4'(v));
    chk("no_wrap_15", cif.wrap, 0);
    up(4'd0);
    chk("wrap_up", cif.wrap, 1);
    chk("wrap_up_noerr", cif.error, 0);
    dn(4'd15);
    chk("wrap_dn", cif.wrap, 1);
    dn(4'd14);
    chk("wrap_dn_once", cif.wrap, 0);
    chk("still_locked", cif.locked, 1);

    step(4'd15, 1'b0, 1'b1, 4'd15);
    step(4'd0, 1'b0, 1'b1, 4'd0);
    chk("load0_no_wrap", cif.wrap, 0);
    chk("load0_no_err", cif.error, 0);

    step(4'd9, 1'b0, 1'b1, 4'd9);
    up(4'd11);
    chk("mis_error", cif.error, 1);
    chk("mis_errcnt", cif.err_count, 1);
    chk("mis_unlock", cif.locked, 0);
    chk("mis_no_wrap", cif.wrap, 0);
    up(4'd12);
    chk("err_pulse_end", cif.error, 0);
    up(4'd13);
    chk("relock_pending", cif.locked, 0);
    up(4'd14);
    chk("relock", cif.locked, 1);

    step(4'd4, 1'b0, 1'b1, 4'd4);
    step(4'd12, 1'b0, 1'b1, 4'd12);
    chk("load12_err", cif.error, 0);
    chk("load12_wrap", cif.wrap, 0);
    up(4'd13);
    chk("prev_is_12", cif.error, 0);
    step(4'd2, 1'b0, 1'b1, 4'd3);
    chk("load_mis_err", cif.error, 1);
    chk("load_mis_cnt", cif.err_count, 2);

    repeat (300) force_err();
    chk("sat_errcnt", cif.err_count, 255);
    chk("sat_err_pulse", cif.error, 1);

    relock();
    chk("sat_relock", cif.locked, 1);
    cif.clear_err = 1'b1;
    up(4'(p + 4'd3));
    cif.clear_err = 1'b0;
    chk("clr_with_err", cif.err_count, 1);

    cif.clear_err = 1'b1;
    @(posedge clk);
    #1;
    cif.clear_err = 1'b0;
    chk("clr_alone", cif.err_count, 0);

    repeat (7) force_err();
    relock();
    chk("pre_rst_cnt", cif.err_count, 7);
    chk("pre_rst_lock", cif.locked, 1);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_locked", cif.locked, 0);
    chk("async_errcnt", cif.err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    up(4'(p + 4'd7));
    chk("post_rst_noerr", cif.error, 0);
    up(4'(p + 4'd5));
    chk("acq_mis_noerr", cif.error, 0);
    chk("acq_mis_cnt", cif.err_count, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/count_sequence_checker.md
# count_sequence_checker

Synchronous monitor for the 4-bit up/down loadable counter's output bus. It samples the counter value on a strobe and checks every step against the commanded direction and load. It reports lock, sequence errors, and wrap-around events. It sits on the reader side of the counter interface, in the lab test harness and on the board's status LEDs.

## Interface
- WIDTH, 4, width of the monitored count bus
- LOCK_COUNT, 3, consecutive correct transitions required before Locked asserts (range 1..15)
- ERR_WIDTH, 8, width of the saturating error counter
- Clock  input  1  sole clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low; clears all state immediately
- Sample  input  1  one-cycle strobe: Value holds a new counter value this cycle
- Value  input  WIDTH  counter output being monitored
- Count  input  1  direction applied for this step: 0 = up (+1), 1 = down (-1)
- Load  input  1  this step was a parallel load; expected value is In
- In  input  WIDTH  load value presented to the counter
- ClearErr  input  1  synchronous clear of ErrCount
- Locked  output  1  level; checker has verified LOCK_COUNT consecutive steps
- Error  output  1  one-cycle pulse; mismatch detected while locked
- Wrap  output  1  one-cycle pulse; accepted step crossed max->0 (up) or 0->max (down)
- ErrCount  output  ERR_WIDTH  number of Error pulses, saturating at all-ones

## Operation
- Internal state: Prev (WIDTH), Good (4-bit run length), FSM state in {IDLE, ACQUIRE, LOCKED}.
- Cycles with Sample = 0:
  - No state change.
  - Load, Count, and In are ignored.
- Expected value on a Sample cycle:
  - Load = 1: Exp = In.
  - Load = 0, Count = 0: Exp = Prev + 1, modulo 2^WIDTH.
  - Load = 0, Count = 1: Exp = Prev - 1, modulo 2^WIDTH.
  - Load has priority over Count.
- IDLE:
  - Entered on reset.
  - First Sample: Prev <= Value, Good <= 0, go to ACQUIRE.
  - No check is made on this first Sample.
- ACQUIRE, correct Sample (Value == Exp):
  - Prev <= Value, Good <= Good + 1.
  - If Good + 1 == LOCK_COUNT, go to LOCKED.
- ACQUIRE, mismatch:
  - Prev <= Value (resynchronise), Good <= 0.
  - No Error pulse and no ErrCount change.
- LOCKED, correct Sample: Prev <= Value.
- LOCKED, mismatch:
  - Error pulses.
  - ErrCount increments.
  - Prev <= Value, Good <= 0, go to ACQUIRE.
- Wrap:
  - Pulses only on a correct, non-load step, in ACQUIRE or LOCKED.
  - Up step: Prev == max and Value == 0.
  - Down step: Prev == 0 and Value == max.
  - A load of 0 from max is not a wrap.
- ErrCount:
  - Saturates at 2^ERR_WIDTH - 1 and never rolls over.
  - ClearErr alone sets it to 0.
  - ClearErr in the same cycle as an Error increment sets it to 1.
- Locked = 1 exactly when the state is LOCKED.

## Timing
- All outputs are registered.
- Error, Wrap, and Locked changes appear on the Clock edge that consumes the Sample, i.e. one cycle after Sample is presented.
- Error and Wrap last exactly one cycle each.
- Back-to-back Samples (every cycle) are supported at full rate with no stalls.
- Reset values: Locked = 0, Error = 0, Wrap = 0, ErrCount = 0, state IDLE, Prev = 0, Good = 0.
- Reset asserted mid-operation:
  - All outputs clear asynchronously.
  - A pending Error or Wrap pulse is lost.
  - The next Sample after release is treated as the first Sample (IDLE path).
- Error and Wrap are mutually exclusive, because a mismatch is never a wrap.

## Test plan
- Reset release, then Samples 5, 6, 7, 8 with Count = 0 (LOCK_COUNT = 3):
  - Locked rises one cycle after the Sample of 8.
  - Error stays 0.
- Locked, up count, Samples 14, 15, 0 with Count = 0: Wrap pulses once, after the 0 Sample. Then Count = 1 with Samples 15, 14: Wrap pulses once, after 15.
- Locked at Prev = 9, Sample Value = 11 with Count = 0:
  - Error pulses, ErrCount goes 0 -> 1, Locked falls.
  - Re-lock requires 3 further correct steps counted from 11.
- Locked at Prev = 4, Load = 1, In = 12, Value = 12: no Error, no Wrap, Prev = 12. Then Load = 1, In = 3, Value = 2: Error pulses.
- Force 300 errors: ErrCount holds at 255. ClearErr asserted together with a mismatch: ErrCount = 1 on the next cycle.
- Assert Reset while locked with ErrCount = 7, between Clock edges:
  - Locked = 0 and ErrCount = 0 immediately.
  - The first Sample after release produces no Error, whatever its Value.
